// File: rtl/tick_capture_pkg.sv
// Shared register map and CSR bit positions for tick_capture.
// Firmware headers are generated from these constants, so keep them in sync.
package tick_capture_pkg;

  // Word addresses, decoded on wb_addr[3:0]
  localparam logic [3:0] ADDR_CSR       = 4'h0;
  localparam logic [3:0] ADDR_TIME_CAP  = 4'h1;
  localparam logic [3:0] ADDR_TIME_LIVE = 4'h2;
  localparam logic [3:0] ADDR_CH_BASE   = 4'h8;

  // CSR bit positions
  localparam int CSR_EN      = 0;
  localparam int CSR_HW_EN   = 1;
  localparam int CSR_SW_CAP  = 2;
  localparam int CSR_IRQ_EN  = 3;
  localparam int CSR_PENDING = 8;
  localparam int CSR_OVERRUN = 9;
  localparam int CSR_SEQ_LSB = 16;
  localparam int SEQ_W       = 8;

endpackage

// File: rtl/tick_capture_ch.sv
// One tick channel: free counter, optional last-capture baseline and the
// capture register. Capture samples the pre-increment counter, so a tick
// coincident with the capture lands in the next interval.
module tick_capture_ch #(
  parameter int CNT_W = 16,
  parameter bit DELTA = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             tick_i,
  input  logic             cap_ev_i,
  output logic [CNT_W-1:0] cap_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cap_q;
  logic [CNT_W-1:0] cap_d;

  // Tick counter, wraps modulo 2^CNT_W, holds while disabled
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                cnt_q <= '0;
    else if (en_i && tick_i) cnt_q <= cnt_q + CNT_W'(1);
  end

  if (DELTA) begin : g_delta
    logic [CNT_W-1:0] last_q;
    // Baseline for the next delta is the value just reported against
    always_ff @(posedge clk or posedge rst) begin
      if (rst)           last_q <= '0;
      else if (cap_ev_i) last_q <= cnt_q;
    end
    assign cap_d = cnt_q - last_q;
  end else begin : g_abs
    assign cap_d = cnt_q;
  end

  // Capture register, loaded atomically with the other channels
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           cap_q <= '0;
    else if (cap_ev_i) cap_q <= cap_d;
  end

  assign cap_o = cap_q;

endmodule

// File: rtl/tick_capture.sv
// Tick-rate capture peripheral: Wishbone slave, CSR, time counter and
// capture sequencing around N_CH tick_capture_ch instances.
module tick_capture
  import tick_capture_pkg::*;
#(
  parameter int N_CH   = 2,
  parameter int CNT_W  = 16,
  parameter int TIME_W = 32,
  parameter bit DELTA  = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] ticks,
  input  logic            tick_cap,
  output logic            irq,
  input  logic [7:0]      wb_addr,
  output logic [31:0]     wb_rdata,
  input  logic [31:0]     wb_wdata,
  input  logic            wb_we,
  input  logic            wb_cyc,
  output logic            wb_ack
);

  logic              ack_q, wr_q;
  logic [3:0]        waddr_q;
  logic [31:0]       wdata_q, rdata_q, rdata_d;
  logic              en_q, hw_en_q, irq_en_q, pending_q, overrun_q, irq_q;
  logic [SEQ_W-1:0]  seq_q;
  logic [TIME_W-1:0] time_q, time_cap_q;
  logic [N_CH-1:0][CNT_W-1:0] cap;

  logic wr_csr, sw_cap, cap_ev, pend_clr, ovr_clr;

  // Writes act one edge after the ack cycle from the registered strobe
  assign wr_csr   = wr_q && (waddr_q == ADDR_CSR);
  assign sw_cap   = wr_csr && wdata_q[CSR_SW_CAP];
  assign pend_clr = wr_csr && wdata_q[CSR_PENDING];
  assign ovr_clr  = wr_csr && wdata_q[CSR_OVERRUN];
  assign cap_ev   = (tick_cap && hw_en_q) || sw_cap;

  // Bus handshake: one wait state, registered write strobe and read data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_q   <= 1'b0;
      wr_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      ack_q <= wb_cyc && !ack_q;
      wr_q  <= wb_cyc && wb_we && !ack_q;
      if (wb_cyc && !ack_q) begin
        waddr_q <= wb_addr[3:0];
        wdata_q <= wb_wdata;
      end
      rdata_q <= (!wb_cyc || ack_q) ? 32'h0 : rdata_d;
    end
  end

  // Read mux; sampled before any coincident capture updates the registers
  always_comb begin
    rdata_d = '0;
    if (wb_addr[3:0] == ADDR_CSR) begin
      rdata_d[CSR_EN]                    = en_q;
      rdata_d[CSR_HW_EN]                 = hw_en_q;
      rdata_d[CSR_IRQ_EN]                = irq_en_q;
      rdata_d[CSR_PENDING]               = pending_q;
      rdata_d[CSR_OVERRUN]               = overrun_q;
      rdata_d[CSR_SEQ_LSB +: SEQ_W]      = seq_q;
    end else if (wb_addr[3:0] == ADDR_TIME_CAP) begin
      rdata_d[TIME_W-1:0] = time_cap_q;
    end else if (wb_addr[3:0] == ADDR_TIME_LIVE) begin
      rdata_d[TIME_W-1:0] = time_q;
    end else begin
      for (int k = 0; k < N_CH; k++)
        if (wb_addr[3:0] == ADDR_CH_BASE + 4'(k)) rdata_d[CNT_W-1:0] = cap[k];
    end
  end

  // CSR, time base, capture sequencing and interrupt
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q       <= 1'b0;
      hw_en_q    <= 1'b0;
      irq_en_q   <= 1'b0;
      pending_q  <= 1'b0;
      overrun_q  <= 1'b0;
      irq_q      <= 1'b0;
      seq_q      <= '0;
      time_q     <= '0;
      time_cap_q <= '0;
    end else begin
      time_q <= time_q + TIME_W'(1);
      if (wr_csr) begin
        en_q     <= wdata_q[CSR_EN];
        hw_en_q  <= wdata_q[CSR_HW_EN];
        irq_en_q <= wdata_q[CSR_IRQ_EN];
      end
      if (cap_ev) begin
        time_cap_q <= time_q;
        seq_q      <= seq_q + SEQ_W'(1);
      end
      // A capture beats a coincident clear
      if (cap_ev)        pending_q <= 1'b1;
      else if (pend_clr) pending_q <= 1'b0;
      // Overrun only if the previous capture was left unacknowledged
      if (cap_ev && pending_q && !pend_clr) overrun_q <= 1'b1;
      else if (ovr_clr)                     overrun_q <= 1'b0;
      irq_q <= pending_q && irq_en_q;
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    tick_capture_ch #(.CNT_W(CNT_W), .DELTA(DELTA)) u_ch (
      .clk      (clk),
      .rst      (rst),
      .en_i     (en_q),
      .tick_i   (ticks[k]),
      .cap_ev_i (cap_ev),
      .cap_o    (cap[k])
    );
  end

  assign wb_ack   = ack_q;
  assign wb_rdata = rdata_q;
  assign irq      = irq_q;

  logic unused;
  assign unused = &{1'b0, wb_addr[7:4], wdata_q[31:10], wdata_q[7:4]};

endmodule

// File: tb/tb_tick_capture.sv
// Directed bench for tick_capture: one absolute-mode instance (defaults)
// and one delta-mode instance with 8-bit counters sharing tick inputs.
module tb_tick_capture;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  ticks = '0;
  logic        tick_cap = 1'b0;
  logic [7:0]  wb_addr = '0;
  logic [31:0] wb_wdata = '0;
  logic        wb_we = 1'b0;
  logic [1:0]  cyc = '0;
  logic        irq0, irq1, ack0, ack1;
  logic [31:0] rd0, rd1;

  always #5 clk = ~clk;

  tick_capture u_abs (
    .clk(clk), .rst(rst), .ticks(ticks), .tick_cap(tick_cap), .irq(irq0),
    .wb_addr(wb_addr), .wb_rdata(rd0), .wb_wdata(wb_wdata), .wb_we(wb_we),
    .wb_cyc(cyc[0]), .wb_ack(ack0)
  );

  tick_capture #(.N_CH(2), .CNT_W(8), .TIME_W(32), .DELTA(1'b1)) u_dlt (
    .clk(clk), .rst(rst), .ticks(ticks), .tick_cap(tick_cap), .irq(irq1),
    .wb_addr(wb_addr), .wb_rdata(rd1), .wb_wdata(wb_wdata), .wb_we(wb_we),
    .wb_cyc(cyc[1]), .wb_ack(ack1)
  );

  int          nvec = 0;
  int          nfail = 0;
  logic [31:0] sbq[$];
  logic [31:0] tcount;
  logic [31:0] exp_time;

  // Reference free-running time base
  always @(posedge clk or posedge rst)
    if (rst) tcount <= '0;
    else     tcount <= tcount + 32'd1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic bus_timeout(input string tag);
    nvec++;
    nfail++;
    $display("FAIL %s: no ack within bound", tag);
  endtask

  task automatic rd(input bit s, input logic [7:0] a, input logic [31:0] e, input string tag);
    bit got = 0;
    int lat = 0;
    @(negedge clk);
    sbq.push_back((a == 8'h02) ? tcount : e);
    wb_addr = a; wb_we = 1'b0; cyc[s] = 1'b1;
    for (int i = 0; i < 4 && !got; i++) begin
      @(negedge clk);
      if ((s ? ack1 : ack0) === 1'b1) got = 1; else lat++;
    end
    cyc[s] = 1'b0;
    if (got) begin
      check(tag, s ? rd1 : rd0, sbq.pop_front());
      check({tag, "_lat"}, 32'(lat), 32'd0);
    end else begin
      void'(sbq.pop_front());
      bus_timeout(tag);
    end
    @(negedge clk);
    check({tag, "_ack_drop"}, {31'b0, s ? ack1 : ack0}, 32'd0);
  endtask

  // Write; tcap/tmask are driven into the edge where the write lands
  task automatic wr(input bit s, input logic [7:0] a, input logic [31:0] d,
                    input logic tcap, input logic [1:0] tmask);
    bit got = 0;
    @(negedge clk);
    wb_addr = a; wb_wdata = d; wb_we = 1'b1; cyc[s] = 1'b1;
    for (int i = 0; i < 4 && !got; i++) begin
      @(negedge clk);
      if ((s ? ack1 : ack0) === 1'b1) got = 1;
    end
    if (!got) bus_timeout("write");
    cyc[s] = 1'b0; wb_we = 1'b0; tick_cap = tcap; ticks = tmask;
    @(negedge clk);
    tick_cap = 1'b0; ticks = '0;
  endtask

  task automatic hcap();
    @(negedge clk);
    tick_cap = 1'b1; exp_time = tcount;
    @(negedge clk);
    tick_cap = 1'b0;
  endtask

  task automatic tick_run(input int n, input logic [1:0] m);
    @(negedge clk);
    ticks = m;
    repeat (n) @(negedge clk);
    ticks = '0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_irq", {31'b0, irq0}, 32'd0);
    check("rst_ack", {31'b0, ack0}, 32'd0);
    check("rst_rdata", rd0, 32'd0);
    rd(0, 8'h00, 32'h0, "rst_csr");
    rd(0, 8'h08, 32'h0, "rst_ch0");
    rd(1, 8'h00, 32'h0, "rst_csr_dlt");

    // Absolute mode, hardware capture
    wr(0, 8'h00, 32'h3, 1'b0, 2'b00);
    rd(0, 8'h00, 32'h3, "csr_en");
    tick_run(100, 2'b01);
    tick_run(37, 2'b10);
    hcap();
    rd(0, 8'h08, 32'd100, "abs_ch0");
    rd(0, 8'h09, 32'd37, "abs_ch1");
    rd(0, 8'h01, exp_time, "time_cap");
    rd(0, 8'h00, 32'h0001_0103, "csr_cap1");
    check("irq_masked", {31'b0, irq0}, 32'd0);
    rd(0, 8'h02, 32'h0, "time_live");
    rd(0, 8'h0a, 32'h0, "unmapped_a");
    rd(0, 8'h05, 32'h0, "unmapped_5");

    // Overrun and W1C
    hcap();
    rd(0, 8'h00, 32'h0002_0303, "csr_overrun");
    wr(0, 8'h00, 32'h303, 1'b0, 2'b00);
    rd(0, 8'h00, 32'h0002_0003, "csr_w1c");
    hcap();
    wr(0, 8'h00, 32'h303, 1'b1, 2'b00);
    rd(0, 8'h00, 32'h0004_0103, "w1c_vs_cap");
    wr(0, 8'h00, 32'h303, 1'b0, 2'b00);

    // tick_cap + sw_cap + tick in one cycle
    wr(0, 8'h00, 32'h307, 1'b1, 2'b01);
    rd(0, 8'h00, 32'h0005_0103, "simul_seq");
    rd(0, 8'h08, 32'd100, "simul_pre");
    hcap();
    rd(0, 8'h08, 32'd101, "simul_next");
    rd(0, 8'h00, 32'h0006_0303, "csr_ovr2");

    // Interrupt latency
    wr(0, 8'h00, 32'h30b, 1'b0, 2'b00);
    check("irq_off", {31'b0, irq0}, 32'd0);
    @(negedge clk); tick_cap = 1'b1;
    @(negedge clk); tick_cap = 1'b0;
    check("irq_lag", {31'b0, irq0}, 32'd0);
    @(negedge clk);
    check("irq_rise", {31'b0, irq0}, 32'd1);

    // Delta mode, 8-bit counters, via software capture
    wr(1, 8'h00, 32'h1, 1'b0, 2'b00);
    tick_run(50, 2'b01);
    wr(1, 8'h00, 32'h5, 1'b0, 2'b00);
    rd(1, 8'h08, 32'd50, "dlt_50");
    tick_run(20, 2'b01);
    wr(1, 8'h00, 32'h5, 1'b0, 2'b00);
    rd(1, 8'h08, 32'd20, "dlt_20");
    tick_run(180, 2'b01);
    wr(1, 8'h00, 32'h5, 1'b0, 2'b00);
    rd(1, 8'h08, 32'd180, "dlt_180");
    tick_run(10, 2'b01);
    wr(1, 8'h00, 32'h5, 1'b0, 2'b00);
    rd(1, 8'h08, 32'd10, "dlt_wrap");
    rd(1, 8'h09, 32'd0, "dlt_ch1");
    rd(1, 8'h00, 32'h0004_0301, "dlt_csr");

    // Reset in the middle of a read
    @(negedge clk);
    wb_addr = 8'h00; wb_we = 1'b0; cyc[0] = 1'b1;
    @(negedge clk);
    check("pre_rst_ack", {31'b0, ack0}, 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_ack", {31'b0, ack0}, 32'd0);
    check("mid_rst_irq", {31'b0, irq0}, 32'd0);
    check("mid_rst_rdata", rd0, 32'd0);
    cyc[0] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    rd(0, 8'h00, 32'h0, "post_rst_csr");
    rd(0, 8'h08, 32'h0, "post_rst_ch0");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
